// File: rtl/reg_file_read_ctrlr_pkg.sv
// Shared constants and types for the register-file read controller.
// Build option RF_WB_BYPASS_EN enables write-back forwarding in the top level.
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 2**ADDR_W;

  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

endpackage

// File: rtl/reg_file_read_ctrlr_if.sv
// Decode / write-back facing bus of the register-file read controller.
// Signal names follow the pipeline's w_* naming.
interface reg_file_read_ctrlr_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) ();

  logic              w_rd_req;
  logic [ADDR_W-1:0] w_rd_addr_s;
  logic [ADDR_W-1:0] w_rd_addr_t;
  logic              w_rd_use_s;
  logic              w_rd_use_t;
  logic              w_rd_grant;
  logic              w_stall;
  logic              w_rd_valid;
  logic [DATA_W-1:0] w_rd_data_s;
  logic [DATA_W-1:0] w_rd_data_t;
  logic              w_issue_valid;
  logic [ADDR_W-1:0] w_issue_waddr;
  logic              w_issue_full;
  logic              w_wb_en;
  logic [ADDR_W-1:0] w_wb_addr;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_sb_err;

  modport master (
    output w_rd_req, w_rd_addr_s, w_rd_addr_t, w_rd_use_s, w_rd_use_t,
    output w_issue_valid, w_issue_waddr, w_wb_en, w_wb_addr, w_wb_data,
    input  w_rd_grant, w_stall, w_rd_valid, w_rd_data_s, w_rd_data_t,
    input  w_issue_full, w_sb_err
  );

  modport slave (
    input  w_rd_req, w_rd_addr_s, w_rd_addr_t, w_rd_use_s, w_rd_use_t,
    input  w_issue_valid, w_issue_waddr, w_wb_en, w_wb_addr, w_wb_data,
    output w_rd_grant, w_stall, w_rd_valid, w_rd_data_s, w_rd_data_t,
    output w_issue_full, w_sb_err
  );

endinterface

// File: rtl/reg_file_read_ctrlr_scoreboard.sv
// Per-register outstanding-write counters with saturation, two-address
// pending lookup and a sticky underflow error.
module reg_file_scoreboard #(
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter int CNT_W  = reg_file_pkg::CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_waddr_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [ADDR_W-1:0] look_s_addr_i,
  input  logic [ADDR_W-1:0] look_t_addr_i,
  output logic              issue_full_o,
  output logic              pend_s_o,
  output logic              pend_t_o,
  output logic              last_s_o,
  output logic              last_t_o,
  output logic              sb_err_o
);
  import reg_file_pkg::*;

  localparam int                NREGS     = 2**ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic             err_q;
  logic             err_d;
  logic             inc;
  logic             dec;
  logic             wb_live;

  always_comb begin
    issue_full_o = issue_valid_i && (issue_waddr_i != ZERO_ADDR) &&
                   (cnt_q[issue_waddr_i] == CNT_MAX);
    inc          = issue_valid_i && (issue_waddr_i != ZERO_ADDR) && !issue_full_o;
    wb_live      = wb_en_i && (wb_addr_i != ZERO_ADDR);
    // A write-back with nothing outstanding keeps the count at 0 and flags it.
    dec          = wb_live && (cnt_q[wb_addr_i] != '0);
    err_d        = err_q || (wb_live && (cnt_q[wb_addr_i] == '0));
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc && (issue_waddr_i == ADDR_W'(i))) begin
        cnt_d[i] = cnt_d[i] + CNT_ONE;
      end else begin
        cnt_d[i] = cnt_d[i];
      end
      if (dec && (wb_addr_i == ADDR_W'(i))) begin
        cnt_d[i] = cnt_d[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_d[i];
      end
    end
  end

  always_comb begin
    pend_s_o = (cnt_q[look_s_addr_i] != '0);
    pend_t_o = (cnt_q[look_t_addr_i] != '0);
    last_s_o = (cnt_q[look_s_addr_i] == CNT_ONE);
    last_t_o = (cnt_q[look_t_addr_i] == CNT_ONE);
    sb_err_o = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/reg_file_read_ctrlr.sv
// Register-file read side: storage, scoreboard-gated read grant, registered operands.
// Define RF_WB_BYPASS_EN to forward same-cycle write-back into grant and data.
module reg_file_read_ctrlr #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter int CNT_W  = reg_file_pkg::CNT_W
) (
  input logic                  clock,
  input logic                  reset_n,
  reg_file_read_ctrlr_if.slave bus
);
  import reg_file_pkg::*;

  localparam int                NREGS     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
`ifdef RF_WB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [NREGS];
  logic              pend_s;
  logic              pend_t;
  logic              last_s;
  logic              last_t;
  logic              issue_full;
  logic              sb_err;
  logic              wb_live;
  logic              hazard_s;
  logic              hazard_t;
  logic              grant;
  logic [DATA_W-1:0] rd_s;
  logic [DATA_W-1:0] rd_t;
  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_s_q;
  logic [DATA_W-1:0] data_s_d;
  logic [DATA_W-1:0] data_t_q;
  logic [DATA_W-1:0] data_t_d;

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .issue_valid_i (bus.w_issue_valid),
    .issue_waddr_i (bus.w_issue_waddr),
    .wb_en_i       (bus.w_wb_en),
    .wb_addr_i     (bus.w_wb_addr),
    .look_s_addr_i (bus.w_rd_addr_s),
    .look_t_addr_i (bus.w_rd_addr_t),
    .issue_full_o  (issue_full),
    .pend_s_o      (pend_s),
    .pend_t_o      (pend_t),
    .last_s_o      (last_s),
    .last_t_o      (last_t),
    .sb_err_o      (sb_err)
  );

  // Hazards use pre-edge counts, so a same-cycle issue never blocks its own read.
  always_comb begin
    wb_live  = bus.w_wb_en && (bus.w_wb_addr != ZERO_ADDR);
    hazard_s = bus.w_rd_use_s && (bus.w_rd_addr_s != ZERO_ADDR) && pend_s &&
               !(BYPASS_EN && bus.w_wb_en && (bus.w_wb_addr == bus.w_rd_addr_s) && last_s);
    hazard_t = bus.w_rd_use_t && (bus.w_rd_addr_t != ZERO_ADDR) && pend_t &&
               !(BYPASS_EN && bus.w_wb_en && (bus.w_wb_addr == bus.w_rd_addr_t) && last_t);
    grant    = bus.w_rd_req && !hazard_s && !hazard_t;
    bus.w_rd_grant   = grant;
    bus.w_stall      = bus.w_rd_req && !grant;
    bus.w_issue_full = issue_full;
  end

  always_comb begin
    if (bus.w_rd_addr_s == ZERO_ADDR) begin
      rd_s = '0;
    end else if (BYPASS_EN && wb_live && (bus.w_wb_addr == bus.w_rd_addr_s)) begin
      rd_s = bus.w_wb_data;
    end else begin
      rd_s = mem_q[bus.w_rd_addr_s];
    end
    if (bus.w_rd_addr_t == ZERO_ADDR) begin
      rd_t = '0;
    end else if (BYPASS_EN && wb_live && (bus.w_wb_addr == bus.w_rd_addr_t)) begin
      rd_t = bus.w_wb_data;
    end else begin
      rd_t = mem_q[bus.w_rd_addr_t];
    end
  end

  always_comb begin
    valid_d = grant;
    if (grant) begin
      data_s_d = rd_s;
      data_t_d = rd_t;
    end else begin
      data_s_d = data_s_q;
      data_t_d = data_t_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_live) begin
      mem_q[bus.w_wb_addr] <= bus.w_wb_data;
    end else begin
      mem_q[bus.w_wb_addr] <= mem_q[bus.w_wb_addr];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      data_s_q <= '0;
      data_t_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_s_q <= data_s_d;
      data_t_q <= data_t_d;
    end
  end

  assign bus.w_rd_valid  = valid_q;
  assign bus.w_rd_data_s = data_s_q;
  assign bus.w_rd_data_t = data_t_q;
  assign bus.w_sb_err    = sb_err;

endmodule

// File: doc/reg_file_read_ctrlr.md
Name: reg_file_read_ctrlr

Overview:
- Read side of the register file: 32x32 storage, two synchronous read ports and one write-back port.
- A per-register pending-write scoreboard gates reads. A read request is granted only when neither source register has an outstanding write.
- Write-back data may bypass into a granted read. Sits between decode (read requests, destination issue) and write-back (the write enable/address produced by the write-address controller).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- CNT_W, 2, per-register outstanding-write counter width (max 2**CNT_W-1 in flight)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- w_rd_req  in  1  decode requests operand read this cycle
- w_rd_addr_s  in  ADDR_W  source s address
- w_rd_addr_t  in  ADDR_W  source t address
- w_rd_use_s  in  1  source s actually used (ignore hazard if 0)
- w_rd_use_t  in  1  source t actually used
- w_rd_grant  out  1  combinational: request accepted this cycle
- w_stall  out  1  combinational: w_rd_req & ~w_rd_grant
- w_rd_valid  out  1  registered: data outputs valid (cycle after grant)
- w_rd_data_s  out  DATA_W  registered operand s
- w_rd_data_t  out  DATA_W  registered operand t
- w_issue_valid  in  1  granted instruction will write a register
- w_issue_waddr  in  ADDR_W  its destination
- w_issue_full  out  1  combinational: destination counter saturated; issue refused
- w_wb_en  in  1  write-back enable
- w_wb_addr  in  ADDR_W  write-back address
- w_wb_data  in  DATA_W  write-back data
- w_sb_err  out  1  sticky: write-back to register with count 0

Behaviour:
- Reset (async, reset_n=0): all counters 0, all registers 0. w_rd_valid, w_rd_data_s/t and w_sb_err are 0.
- Register 0:
  - always reads 0 and is never pending;
  - writes and issues to it are ignored (no count change, no error).
- Hazard for source x is use_x & addr_x!=0 & cnt[addr_x]!=0.
  - With RF_WB_BYPASS_EN, the hazard is also cleared if w_wb_en & w_wb_addr==addr_x & cnt[addr_x]==1 (last outstanding write landing now).
- w_rd_grant = w_rd_req & ~hazard_s & ~hazard_t.
- Latency: grant in cycle N gives w_rd_valid=1 and data in cycle N+1. Without a grant, w_rd_valid=0 next cycle and the data outputs hold.
- Read data priority:
  1. zero register;
  2. same-cycle write-back match (bypass, macro only);
  3. array contents.
- Issue:
  - accepted when w_issue_valid & ~w_issue_full; cnt[w_issue_waddr]++ at the clock edge.
  - Hazard check uses counts before the increment, so an instruction does not depend on its own destination.
  - w_issue_full = w_issue_valid & waddr!=0 & cnt==max.
- Write-back:
  - when w_wb_en & addr!=0: the array is written and cnt-- at the edge.
  - If cnt==0, the write still occurs, the count stays 0 and w_sb_err is set (cleared only by reset).
- Simultaneous issue and write-back to the same register: net count unchanged. The full check uses the pre-edge count.
- w_rd_addr_s == w_rd_addr_t: same hazard and data for both ports.
- Reset mid-stall: the scoreboard is cleared and the next request is granted.

Optional Feature:
- RF_WB_BYPASS_EN defined: same-cycle write-back forwarding into grant and read data; a dependent read completes on the write-back cycle.
- Undefined: a read is granted only after the count reaches 0 at the edge, so a dependent read is granted the cycle after write-back. Read data always comes from the array (write-before-read is not needed).

Decomposition:
- Package reg_file_pkg:
  - constants DATA_W/ADDR_W/CNT_W defaults;
  - ZERO_REG=0;
  - NUM_REGS;
  - typedefs reg_addr_t, reg_data_t, sb_cnt_t.
- Sub-module reg_file_scoreboard: the counter array, increment/decrement/saturation, pending lookup for two addresses, sticky error.
- The top level holds the storage, bypass muxing and output registers.

Test Plan:
- Reset, then read s=3,t=5 with no issues -> grant same cycle; next cycle w_rd_valid=1, data 0/0.
- Issue waddr=4; wb addr=4 data=0xDEADBEEF two cycles later; read s=4 meanwhile:
  - stall until wb;
  - with macro: grant on the wb cycle, data 0xDEADBEEF next cycle;
  - without macro: grant one cycle later, same data.
- Three issues to reg 7 (CNT_W=2) -> w_issue_full=1 on the fourth attempt and count stays 3. Three wbs -> read of 7 granted.
- Issue and wb to reg 9 in the same cycle with count 1 -> count stays 1 and a read of 9 still stalls.
- Issue/wb to reg 0 with data 0x55 -> read of 0 returns 0, no stall, w_sb_err=0. Then wb to reg 12 with count 0 -> w_sb_err=1, sticky until reset_n low.
- Assert reset_n low while a read is stalled on reg 6 -> outputs 0 immediately; after release, the read of 6 is granted the first cycle.
